// File: rtl/act_pkg.sv
// Shared Q8.8 constants and the response payload for the shared sigmoid pipeline.
package act_pkg;
    localparam int unsigned DATA_W   = 16;
    localparam int unsigned ID_MAX_W = 4;

    localparam logic [DATA_W-1:0] ACT_ONE     = 16'h0100;
    localparam logic [DATA_W-1:0] ACT_SAT_POS = 16'h0600;
    localparam logic [DATA_W-1:0] ACT_SAT_NEG = 16'hFA00;

    typedef struct packed {
        logic [ID_MAX_W-1:0] id;
        logic [DATA_W-1:0]   data;
    } act_resp_t;
endpackage

// File: rtl/activation.sv
// Combinational Q8.8 sigmoid: 0.25-step ROM over |x| <= 6.0, symmetric for negatives, saturated outside.
module activation
    import act_pkg::*;
(
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout_c
);
    logic [DATA_W-1:0] mag;
    logic [4:0]        idx;
    logic [DATA_W-1:0] rom;

    always_comb begin
        mag = din[DATA_W-1] ? DATA_W'(-din) : din;
        idx = 5'(mag >> 6);
        case (idx)
            5'd0:    rom = 16'd128;
            5'd1:    rom = 16'd144;
            5'd2:    rom = 16'd159;
            5'd3:    rom = 16'd174;
            5'd4:    rom = 16'd187;
            5'd5:    rom = 16'd199;
            5'd6:    rom = 16'd209;
            5'd7:    rom = 16'd218;
            5'd8:    rom = 16'd225;
            5'd9:    rom = 16'd232;
            5'd10:   rom = 16'd237;
            5'd11:   rom = 16'd241;
            5'd12:   rom = 16'd244;
            5'd13:   rom = 16'd246;
            5'd14:   rom = 16'd248;
            5'd15:   rom = 16'd250;
            5'd16:   rom = 16'd251;
            5'd17:   rom = 16'd252;
            5'd18:   rom = 16'd253;
            5'd19:   rom = 16'd254;
            5'd20:   rom = 16'd254;
            default: rom = 16'd255;
        endcase

        // Saturation is decided on the signed input, before the ROM
        if ($signed(din) > $signed(ACT_SAT_POS)) begin
            dout_c = ACT_ONE;
        end else if ($signed(din) < $signed(ACT_SAT_NEG)) begin
            dout_c = '0;
        end else if (din[DATA_W-1]) begin
            dout_c = ACT_ONE - rom;
        end else begin
            dout_c = rom;
        end
    end
endmodule

// File: rtl/rr_arbiter.sv
// Round-robin search starting at a registered pointer; pointer moves past the winner on an accepted grant.
module rr_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             advance,
    output logic [N_REQ-1:0] grant_c,
    output logic [ID_W-1:0]  grant_idx_c
);
    localparam int unsigned CW = ID_W + 1;

    logic [ID_W-1:0] ptr_q;
    logic [ID_W-1:0] ptr_d;
    logic [CW-1:0]   cand;
    logic            found;

    always_comb begin
        ptr_d       = ptr_q;
        grant_c     = '0;
        grant_idx_c = '0;
        found       = 1'b0;
        cand        = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = CW'(ptr_q) + CW'(i);
            if (cand >= CW'(N_REQ)) begin
                cand = cand - CW'(N_REQ);
            end
            if (!found && req[cand[ID_W-1:0]]) begin
                found       = 1'b1;
                grant_idx_c = cand[ID_W-1:0];
            end
        end
        if (found && advance) begin
            grant_c[grant_idx_c] = 1'b1;
            ptr_d = (grant_idx_c == ID_W'(N_REQ - 1)) ? '0 : grant_idx_c + ID_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
endmodule

// File: rtl/act_share_arbiter.sv
// Shares one sigmoid unit among N_REQ lanes: round-robin grant, S1 operand register, S2 tagged result register.
module act_share_arbiter #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ID_W   = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [ID_W-1:0]         resp_id,
    output logic [DATA_W-1:0]       resp_data,
    output logic                    busy
);
    import act_pkg::act_resp_t;
    import act_pkg::ID_MAX_W;

    logic              adv_c;
    logic [N_REQ-1:0]  grant_c;
    logic [ID_W-1:0]   grant_idx_c;
    logic [DATA_W-1:0] act_out_c;

    logic              s1_valid_q, s1_valid_d;
    logic [ID_W-1:0]   s1_id_q, s1_id_d;
    logic [DATA_W-1:0] s1_data_q, s1_data_d;
    logic              resp_valid_q, resp_valid_d;
    act_resp_t         resp_q, resp_d;

    // Whole pipeline moves together whenever the output slot is free or being drained
    assign adv_c = ~resp_valid_q | resp_ready;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .req         (req_valid),
        .advance     (adv_c & ~rst),
        .grant_c     (grant_c),
        .grant_idx_c (grant_idx_c)
    );

    activation u_act (
        .din    (s1_data_q),
        .dout_c (act_out_c)
    );

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_id_d      = s1_id_q;
        s1_data_d    = s1_data_q;
        resp_valid_d = resp_valid_q;
        resp_d       = resp_q;
        if (adv_c) begin
            s1_valid_d = |grant_c;
            s1_id_d    = grant_idx_c;
            s1_data_d  = '0;
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (grant_c[i]) begin
                    s1_data_d = req_data[i*DATA_W +: DATA_W];
                end
            end
            resp_valid_d = s1_valid_q;
            resp_d.id    = ID_MAX_W'(s1_id_q);
            resp_d.data  = act_out_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_id_q      <= '0;
            s1_data_q    <= '0;
            resp_valid_q <= 1'b0;
            resp_q       <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_id_q      <= s1_id_d;
            s1_data_q    <= s1_data_d;
            resp_valid_q <= resp_valid_d;
            resp_q       <= resp_d;
        end
    end

    assign req_ready  = grant_c;
    assign resp_valid = resp_valid_q;
    assign resp_id    = ID_W'(resp_q.id);
    assign resp_data  = resp_q.data;
    assign busy       = s1_valid_q | resp_valid_q;
endmodule

// File: tb/tb_act_share_arbiter.sv
// Randomized and directed bench for act_share_arbiter (N_REQ=4 and N_REQ=3) against a queue-style reference.
module tb_act_share_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [3:0]  req_valid;
    logic [63:0] req_data;
    logic [3:0]  req_ready;
    logic        resp_valid, resp_ready, busy;
    logic [1:0]  resp_id;
    logic [15:0] resp_data;

    logic [2:0]  req_valid3;
    logic [47:0] req_data3;
    logic [2:0]  req_ready3;
    logic        resp_valid3, resp_ready3, busy3;
    logic [1:0]  resp_id3;
    logic [15:0] resp_data3;

    act_share_arbiter #(.N_REQ(4), .DATA_W(16), .ID_W(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_data(resp_data),
        .busy(busy));

    act_share_arbiter #(.N_REQ(3), .DATA_W(16), .ID_W(2)) dut3 (
        .clk(clk), .rst(rst), .req_valid(req_valid3), .req_data(req_data3), .req_ready(req_ready3),
        .resp_valid(resp_valid3), .resp_ready(resp_ready3), .resp_id(resp_id3), .resp_data(resp_data3),
        .busy(busy3));

    int vectors;
    int miscompares;

    // Reference: rr pointer, plus the two in-flight slots ([0] operand stage, [1] visible result)
    int          m_ptr;
    bit          m_v[2];
    int          m_id[2];
    logic [15:0] m_d[2];

    function automatic logic [15:0] sig_ref(input logic [15:0] x);
        int  v;
        int  mag;
        int  k;
        int  r;
        real s;
        v = int'($signed(x));
        if (v > 1536) return 16'h0100;
        if (v < -1536) return 16'h0000;
        mag = (v < 0) ? -v : v;
        k = mag / 64;
        s = 1.0 / (1.0 + $exp(-(real'(k) / 4.0)));
        r = $rtoi(256.0 * s + 0.5);
        return (v < 0) ? 16'(256 - r) : 16'(r);
    endfunction

    function automatic logic [15:0] rand_val();
        if ($urandom_range(0, 3) == 0) return 16'($urandom_range(0, 65535));
        return 16'(int'($urandom_range(0, 3584)) - 1792);
    endfunction

    task automatic model_reset();
        m_ptr = 0;
        for (int s = 0; s < 2; s++) begin
            m_v[s] = 1'b0; m_id[s] = 0; m_d[s] = '0;
        end
    endtask

    // One clock on the 4-lane DUT: drive, check against the model, clock, update the model
    task automatic cycle(input logic [3:0] vld, input logic [63:0] dat, input logic rdy,
                         input string tag, output int g);
        logic [3:0] exp_rdy;
        bit         adv;
        req_valid  = vld;
        req_data   = dat;
        resp_ready = rdy;
        #1;
        adv = !m_v[1] || rdy;
        g = -1;
        if (adv) begin
            for (int i = 0; i < 4; i++) begin
                int c;
                c = (m_ptr + i) % 4;
                if (g < 0 && vld[c]) g = c;
            end
        end
        exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0000;
        vectors++;
        if (req_ready !== exp_rdy) begin
            miscompares++;
            $display("FAIL %s req_ready got %b want %b", tag, req_ready, exp_rdy);
        end
        vectors++;
        if (resp_valid !== m_v[1]) begin
            miscompares++;
            $display("FAIL %s resp_valid got %b want %b", tag, resp_valid, m_v[1]);
        end
        if (m_v[1]) begin
            vectors++;
            if (resp_id !== 2'(m_id[1]) || resp_data !== m_d[1]) begin
                miscompares++;
                $display("FAIL %s resp got id=%0d data=%h want id=%0d data=%h",
                         tag, resp_id, resp_data, m_id[1], m_d[1]);
            end
        end
        vectors++;
        if (busy !== (m_v[0] | m_v[1])) begin
            miscompares++;
            $display("FAIL %s busy got %b want %b", tag, busy, m_v[0] | m_v[1]);
        end
        @(posedge clk);
        if (adv) begin
            m_v[1] = m_v[0]; m_id[1] = m_id[0]; m_d[1] = m_d[0];
            m_v[0] = (g >= 0);
            if (g >= 0) begin
                m_id[0] = g;
                m_d[0]  = sig_ref(dat[g*16 +: 16]);
                m_ptr   = (g + 1) % 4;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = '0; req_valid3 = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic check_int(input string name, input int got, input int want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 4'hF; req_valid3 = 3'h7;
        #1;
        check_int("reset_req_ready", int'(req_ready), 0);
        check_int("reset_req_ready3", int'(req_ready3), 0);
        @(posedge clk);
        @(negedge clk);
        check_int("reset_resp_valid", int'(resp_valid), 0);
        check_int("reset_resp_id", int'(resp_id), 0);
        check_int("reset_resp_data", int'(resp_data), 0);
        check_int("reset_busy", int'(busy), 0);
        check_int("reset_busy3", int'(busy3), 0);
        rst = 1'b0; req_valid = '0; req_valid3 = '0;
        model_reset();
    endtask

    task automatic test_single_lane();
        int g;
        cycle(4'b0100, 64'h0, 1'b1, "single_accept", g);
        check_int("single_grant", g, 2);
        cycle(4'b0000, 64'h0, 1'b1, "single_idle", g);
        check_int("single_resp_valid", int'(resp_valid), 1);
        check_int("single_resp_id", int'(resp_id), 2);
        check_int("single_resp_data", int'(resp_data), 16'h0080);
        cycle(4'b0000, 64'h0, 1'b1, "single_drain", g);
    endtask

    task automatic test_saturation();
        int g;
        cycle(4'b0001, 64'h0700, 1'b1, "sat_pos", g);
        check_int("sat_grant0", g, 0);
        cycle(4'b0010, 64'hF900_0000, 1'b1, "sat_neg", g);
        check_int("sat_grant1", g, 1);
        check_int("sat_pos_data", int'(resp_data), 16'h0100);
        cycle(4'b0001, 64'h0600, 1'b1, "sat_edge", g);
        check_int("sat_neg_id", int'(resp_id), 1);
        check_int("sat_neg_data", int'(resp_data), 16'h0000);
        cycle(4'b0000, 64'h0, 1'b1, "sat_idle", g);
        check_int("sat_edge_data", int'(resp_data), 16'h00FF);
        cycle(4'b0000, 64'h0, 1'b1, "sat_drain", g);
    endtask

    task automatic test_round_robin();
        int          g;
        int          order[6];
        logic [63:0] dat;
        order = '{0, 1, 2, 3, 0, 1};
        do_reset();
        for (int k = 0; k < 6; k++) begin
            for (int l = 0; l < 4; l++) dat[l*16 +: 16] = rand_val();
            cycle(4'b1111, dat, 1'b1, "rr", g);
            check_int("rr_grant_order", g, order[k]);
        end
        for (int k = 0; k < 3; k++) cycle(4'b0000, 64'h0, 1'b1, "rr_drain", g);
    endtask

    task automatic test_back_pressure();
        int          g;
        logic [63:0] dat;
        do_reset();
        for (int l = 0; l < 4; l++) dat[l*16 +: 16] = rand_val();
        cycle(4'b0001, dat, 1'b1, "bp_fill0", g);
        cycle(4'b0010, dat, 1'b1, "bp_fill1", g);
        for (int k = 0; k < 3; k++) begin
            cycle(4'b1111, dat, 1'b0, "bp_stall", g);
            check_int("bp_stall_no_grant", g, -1);
            check_int("bp_stall_resp_id", int'(resp_id), 0);
        end
        cycle(4'b1111, dat, 1'b1, "bp_release", g);
        check_int("bp_ptr_frozen", g, 2);
        check_int("bp_second_result", int'(resp_id), 1);
        cycle(4'b1011, dat, 1'b1, "bp_after", g);
        check_int("bp_third_result", int'(resp_id), 2);
        for (int k = 0; k < 3; k++) cycle(4'b0000, 64'h0, 1'b1, "bp_drain", g);
    endtask

    task automatic test_wrap3();
        logic [2:0]  vlds[7];
        int          order[5];
        logic [15:0] vals[7];
        vlds  = '{3'b010, 3'b101, 3'b101, 3'b101, 3'b101, 3'b000, 3'b000};
        order = '{1, 2, 0, 2, 0};
        do_reset();
        resp_ready3 = 1'b1;
        for (int k = 0; k < 7; k++) begin
            vals[k]    = rand_val();
            req_valid3 = vlds[k];
            req_data3  = {vals[k], vals[k], vals[k]};
            #1;
            vectors++;
            if (req_ready3 !== ((k < 5) ? 3'(1 << order[k]) : 3'b000)) begin
                miscompares++;
                $display("FAIL wrap3_grant step %0d got %b", k, req_ready3);
            end
            if (k >= 2) begin
                vectors++;
                if (resp_valid3 !== 1'b1 || resp_id3 !== 2'(order[k-2]) || resp_data3 !== sig_ref(vals[k-2])) begin
                    miscompares++;
                    $display("FAIL wrap3_resp step %0d got v=%b id=%0d data=%h want id=%0d data=%h",
                             k, resp_valid3, resp_id3, resp_data3, order[k-2], sig_ref(vals[k-2]));
                end
            end
            @(posedge clk);
            @(negedge clk);
        end
        req_valid3 = '0;
    endtask

    task automatic test_random(input int ncyc);
        logic [3:0]  vld;
        logic [63:0] dat;
        logic        rdy;
        int          g;
        vld = '0;
        dat = '0;
        for (int c = 0; c < ncyc; c++) begin
            for (int l = 0; l < 4; l++) begin
                if (!vld[l] && $urandom_range(0, 1) == 1) begin
                    vld[l] = 1'b1;
                    dat[l*16 +: 16] = rand_val();
                end
            end
            rdy = ($urandom_range(0, 3) != 0);
            cycle(vld, dat, rdy, "random", g);
            if (g >= 0) vld[g] = 1'b0;
        end
        for (int k = 0; k < 3; k++) cycle(4'b0000, 64'h0, 1'b1, "random_drain", g);
    endtask

    task automatic test_reset_mid_stream();
        int          g;
        logic [63:0] dat;
        for (int l = 0; l < 4; l++) dat[l*16 +: 16] = rand_val();
        cycle(4'b1111, dat, 1'b1, "mid_fill", g);
        cycle(4'b1111, dat, 1'b1, "mid_fill", g);
        check_int("mid_busy_before", int'(busy), 1);
        rst = 1'b1; req_valid = 4'b1111;
        #1;
        check_int("mid_req_ready_in_reset", int'(req_ready), 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_int("mid_resp_valid", int'(resp_valid), 0);
        check_int("mid_busy", int'(busy), 0);
        cycle(4'b1010, dat, 1'b1, "mid_first_grant", g);
        check_int("mid_lowest_index", g, 1);
        for (int k = 0; k < 3; k++) cycle(4'b0000, 64'h0, 1'b1, "mid_drain", g);
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        rst = 1'b1; req_valid = '0; req_data = '0; resp_ready = 1'b1;
        req_valid3 = '0; req_data3 = '0; resp_ready3 = 1'b1;
        model_reset();
        @(negedge clk);
        test_reset();
        test_single_lane();
        test_saturation();
        test_round_robin();
        test_back_pressure();
        test_wrap3();
        do_reset();
        test_random(400);
        test_reset_mid_stream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
